alu_cmd_seq: RTL and testbench

Command sequencer sitting directly upstream of the 4-bit ALU (sel/a/b/c in, out/ovr back).
- Accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered operands into the combinational ALU one command at a time.
- Captures out/ovr into a result register presented over a second valid/ready handshake.
- Keeps a sticky overflow flag for software/status use.

---
 rtl/alu_cmd_seq_pkg.sv | 32 +++
 rtl/alu_cmd_seq_if.sv | 31 +++
 rtl/alu_cmd_seq_cmd_fifo.sv | 81 ++++++++
 rtl/alu_cmd_seq.sv | 149 ++++++++++++++
 tb/tb_alu_cmd_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// and the packed command record that travels through the FIFO.
package alu_cmd_seq_pkg;

  // ALU opcodes; the sequencer forwards them untouched.
  localparam logic [2:0] OP_SUB_AB = 3'b000;
  localparam logic [2:0] OP_SUB_BA = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_AND    = 3'b011;
  localparam logic [2:0] OP_OR     = 3'b100;
  localparam logic [2:0] OP_XOR    = 3'b101;
  localparam logic [2:0] OP_NOTC   = 3'b110;
  localparam logic [2:0] OP_NOP    = 3'b111;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  // One queued ALU command, 15 bits: {sel, a, b, c}.
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Command and result handshake channels between a producer/consumer
// (master) and the sequencer (slave).
interface alu_cmd_seq_if;
  import alu_cmd_seq_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_c;

  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_ovr;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_c,
    input  cmd_ready,
    input  res_valid, res_data, res_ovr,
    output res_ready
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_c,
    output cmd_ready,
    output res_valid, res_data, res_ovr,
    input  res_ready
  );
endinterface

// File: rtl/alu_cmd_seq_cmd_fifo.sv
// Small synchronous command FIFO. Pointers wrap naturally because DEPTH is
// a power of two; push when full and pop when empty are ignored.
module cmd_fifo
  import alu_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  alu_cmd_t      din,
  output alu_cmd_t      dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  alu_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next pointer and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: queues commands, presents one at a time on
// registered ALU operands, captures the combinational ALU answer into a
// result register with its own handshake, and tracks a sticky overflow.
module alu_cmd_seq
  import alu_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_cmd_seq_if.slave  bus,
  output logic [2:0]    alu_sel,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic [3:0]    alu_c,
  input  logic [3:0]    alu_out,
  input  logic          alu_ovr,
  output logic          ovr_sticky,
  input  logic          ovr_clr,
  output logic          busy
);

  alu_cmd_t    cmd_in;
  alu_cmd_t    fifo_dout;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;

  seq_state_e  state_q, state_d;
  alu_cmd_t    alu_q, alu_d;
  logic        res_valid_q, res_valid_d;
  logic [3:0]  res_data_q, res_data_d;
  logic        res_ovr_q, res_ovr_d;
  logic        sticky_q, sticky_d;

  assign cmd_in.sel = bus.cmd_sel;
  assign cmd_in.a   = bus.cmd_a;
  assign cmd_in.b   = bus.cmd_b;
  assign cmd_in.c   = bus.cmd_c;

  // Ready is a function of the registered count only, so a full FIFO
  // refuses a push even in a cycle where it is also being popped.
  assign bus.cmd_ready = ~fifo_full;
  assign fifo_push     = bus.cmd_valid & ~fifo_full;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM next state: load from FIFO head, capture ALU answer, wait for consumer.
  always_comb begin
    state_d     = state_q;
    alu_d       = alu_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovr_d   = res_ovr_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          alu_d    = fifo_dout;
          state_d  = ISSUE;
        end else begin
          state_d  = IDLE;
        end
      end
      ISSUE: begin
        res_data_d  = alu_out;
        res_ovr_d   = alu_ovr;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            alu_d    = fifo_dout;
            state_d  = ISSUE;
          end else begin
            state_d  = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sticky overflow: a capture with overflow beats a coincident clear.
  always_comb begin
    sticky_d = sticky_q;
    if ((state_q == ISSUE) && alu_ovr) begin
      sticky_d = 1'b1;
    end else if (ovr_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 4'h0;
      res_ovr_q   <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_q       <= alu_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovr_q   <= res_ovr_d;
      sticky_q    <= sticky_d;
    end
  end

  assign alu_sel       = alu_q.sel;
  assign alu_a         = alu_q.a;
  assign alu_b         = alu_q.b;
  assign alu_c         = alu_q.c;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovr   = res_ovr_q;
  assign ovr_sticky    = sticky_q;
  assign busy          = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq wired to a behavioural 4-bit ALU.
module tb_alu_cmd_seq;
  import alu_cmd_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b, alu_c, alu_out;
  logic       alu_ovr, ovr_sticky, ovr_clr, busy;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_cmd_seq_if bus();

  alu_cmd_seq #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_out    (alu_out),
    .alu_ovr    (alu_ovr),
    .ovr_sticky (ovr_sticky),
    .ovr_clr    (ovr_clr),
    .busy       (busy)
  );

  // 4-bit ALU: {ovr, out}; subtract ovr is borrow, add ovr is carry out.
  function automatic logic [4:0] alu_model(input logic [2:0] sel, input logic [3:0] a, b, c);
    logic [4:0] r;
    case (sel)
      3'b000:  r = {(a < b), 4'(a - b)};
      3'b001:  r = {(b < a), 4'(b - a)};
      3'b010:  r = {1'b0, a} + {1'b0, b};
      3'b011:  r = {1'b0, a & b};
      3'b100:  r = {1'b0, a | b};
      3'b101:  r = {1'b0, a ^ b};
      3'b110:  r = {1'b0, ~c};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  assign {alu_ovr, alu_out} = alu_model(alu_sel, alu_a, alu_b, alu_c);

  // Vectors {sel, a, b, c, expected_out}
  function automatic logic [18:0] bp_vec(input int i);
    case (i)
      0:       return {3'b010, 4'h1, 4'h1, 4'h0, 4'h2};
      1:       return {3'b001, 4'h2, 4'h7, 4'h0, 4'h5};
      2:       return {3'b101, 4'h6, 4'h5, 4'h0, 4'h3};
      3:       return {3'b110, 4'h0, 4'h0, 4'h0, 4'hF};
      4:       return {3'b000, 4'h8, 4'h1, 4'h0, 4'h7};
      default: return {3'b100, 4'h8, 4'h1, 4'h0, 4'h9};
    endcase
  endfunction

  function automatic logic [18:0] tp_vec(input int i);
    case (i)
      0:       return {3'b101, 4'hA, 4'h5, 4'h0, 4'hF};
      1:       return {3'b011, 4'hC, 4'h6, 4'h0, 4'h4};
      2:       return {3'b100, 4'h1, 4'h2, 4'h0, 4'h3};
      default: return {3'b110, 4'h0, 4'h0, 4'h3, 4'hC};
    endcase
  endfunction

  // OR with b=0: result equals a, handy for order tracking.
  function automatic logic [18:0] or_vec(input int i);
    return {3'b100, 4'(i), 4'h0, 4'h0, 4'(i)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input logic [18:0] v);
    bus.cmd_valid = 1'b1;
    {bus.cmd_sel, bus.cmd_a, bus.cmd_b, bus.cmd_c} = v[18:4];
  endtask

  task automatic idle_cmd;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ovr_clr = 1'b0; bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_sel = 3'b000; bus.cmd_a = 4'h0; bus.cmd_b = 4'h0; bus.cmd_c = 4'h0;
    tick;
    checks++;
    if ({alu_sel, alu_a, alu_b, alu_c, bus.res_valid, bus.res_data, bus.res_ovr, ovr_sticky, busy} !== 23'd0) begin
      errors++; $display("FAIL reset_outputs: got sel=%h a=%h b=%h c=%h rv=%b rd=%h ro=%b st=%b busy=%b, want all 0",
        alu_sel, alu_a, alu_b, alu_c, bus.res_valid, bus.res_data, bus.res_ovr, ovr_sticky, busy);
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({bus.cmd_ready, busy, bus.res_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_release: got rdy=%b busy=%b rv=%b, want 1 0 0", bus.cmd_ready, busy, bus.res_valid);
    end
  endtask

  task automatic test_single_sub;
    bus.res_ready = 1'b1;
    drive_vec({3'b000, 4'h3, 4'h5, 4'h0, 4'h0});
    tick;                         // edge N: push
    idle_cmd;
    checks++;
    if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL sub_N: res_valid got %b want 0", bus.res_valid); end
    tick;                         // edge N+1: load
    checks++;
    if ({bus.res_valid, alu_sel, alu_a, alu_b} !== {1'b0, 3'b000, 4'h3, 4'h5}) begin
      errors++; $display("FAIL sub_load: got rv=%b sel=%h a=%h b=%h want 0 0 3 5", bus.res_valid, alu_sel, alu_a, alu_b);
    end
    tick;                         // edge N+2: result
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_ovr, ovr_sticky} !== {1'b1, 4'hE, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_result: got rv=%b d=%h ovr=%b st=%b want 1 E 1 1",
        bus.res_valid, bus.res_data, bus.res_ovr, ovr_sticky);
    end
    tick;
    checks++;
    if ({bus.res_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL sub_done: got rv=%b busy=%b want 0 0", bus.res_valid, busy);
    end
  endtask

  task automatic test_add_ovr_clr;
    bus.res_ready = 1'b1;
    drive_vec({3'b010, 4'h9, 4'h8, 4'h0, 4'h0});
    tick; idle_cmd; tick; tick;
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_ovr} !== {1'b1, 4'h1, 1'b1}) begin
      errors++; $display("FAIL add_result: got rv=%b d=%h ovr=%b want 1 1 1", bus.res_valid, bus.res_data, bus.res_ovr);
    end
    tick;
    ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
    checks++;
    if (ovr_sticky !== 1'b0) begin errors++; $display("FAIL clr_plain: sticky got %b want 0", ovr_sticky); end
    drive_vec({3'b010, 4'h9, 4'h8, 4'h0, 4'h0});
    tick; idle_cmd; tick;          // loaded, ISSUE during next cycle
    ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
    checks++;
    if ({ovr_sticky, bus.res_valid} !== 2'b11) begin
      errors++; $display("FAIL clr_vs_set: got st=%b rv=%b want 1 1", ovr_sticky, bus.res_valid);
    end
    tick;
    ovr_clr = 1'b1; tick; ovr_clr = 1'b0;
    checks++;
    if (ovr_sticky !== 1'b0) begin errors++; $display("FAIL clr_again: sticky got %b want 0", ovr_sticky); end
  endtask

  task automatic test_backpressure;
    int k;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_vec(bp_vec(i));
      tick;
      checks++;
      if (bus.cmd_ready !== ((i < 4) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL bp_ready_%0d: got %b want %b", i, bus.cmd_ready, (i < 4));
      end
    end
    drive_vec(bp_vec(5));
    for (int j = 0; j < 2; j++) begin
      tick;
      checks++;
      if ({bus.cmd_ready, bus.res_valid, bus.res_data} !== {1'b0, 1'b1, 4'h2}) begin
        errors++; $display("FAIL bp_stall_%0d: got rdy=%b rv=%b d=%h want 0 1 2", j, bus.cmd_ready, bus.res_valid, bus.res_data);
      end
    end
    bus.res_ready = 1'b1;
    tick;                          // first pop
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", bus.cmd_ready); end
    tick;                          // sixth accepted
    idle_cmd;
    k = 1;
    for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
      if (bus.res_valid) begin
        logic [18:0] v;
        v = bp_vec(k);
        checks++;
        if ({bus.res_ovr, bus.res_data} !== {1'b0, v[3:0]}) begin
          errors++; $display("FAIL bp_order_%0d: got ovr=%b d=%h want 0 %h", k, bus.res_ovr, bus.res_data, v[3:0]);
        end
        k++;
      end
      tick;
    end
    checks++;
    if (k != 6) begin errors++; $display("FAIL bp_timeout: got %0d results want 6", k); end
  endtask

  task automatic test_back_to_back;
    int k, last;
    k = 0; last = 0;
    bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 4) drive_vec(tp_vec(cyc)); else idle_cmd;
      tick;
      if (bus.res_valid) begin
        logic [18:0] v;
        v = tp_vec(k);
        checks++;
        if ({bus.res_ovr, bus.res_data} !== {1'b0, v[3:0]}) begin
          errors++; $display("FAIL tp_data_%0d: got ovr=%b d=%h want 0 %h", k, bus.res_ovr, bus.res_data, v[3:0]);
        end
        if (k > 0) begin
          checks++;
          if (cyc - last != 2) begin errors++; $display("FAIL tp_spacing_%0d: got %0d want 2", k, cyc - last); end
        end
        last = cyc;
        k++;
      end
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL tp_count: got %0d want 4", k); end
  endtask

  task automatic test_push_pop_full_minus_one;
    int k;
    bus.res_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin drive_vec(or_vec(i)); tick; end
    checks++;
    if ({dut.fifo_count, bus.res_valid, bus.res_data} !== {3'd3, 1'b1, 4'h1}) begin
      errors++; $display("FAIL pp_pre: got cnt=%0d rv=%b d=%h want 3 1 1", dut.fifo_count, bus.res_valid, bus.res_data);
    end
    drive_vec(or_vec(5));
    bus.res_ready = 1'b1;
    tick;
    idle_cmd;
    checks++;
    if ({dut.fifo_count, bus.cmd_ready} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL pp_count: got cnt=%0d rdy=%b want 3 1", dut.fifo_count, bus.cmd_ready);
    end
    k = 2;
    for (int cyc = 0; cyc < 40 && k <= 5; cyc++) begin
      if (bus.res_valid) begin
        checks++;
        if (bus.res_data !== 4'(k)) begin errors++; $display("FAIL pp_order_%0d: got %h want %h", k, bus.res_data, 4'(k)); end
        k++;
      end
      tick;
    end
    checks++;
    if ((k != 6) || (busy !== 1'b0)) begin errors++; $display("FAIL pp_drain: got k=%0d busy=%b want 6 0", k, busy); end
  endtask

  task automatic test_wrap_scoreboard;
    logic [4:0] q[$];
    logic [4:0] exp;
    logic [2:0] pre;
    logic       will_push, will_pop;
    int sent, got, both;
    sent = 0; got = 0; both = 0;
    for (int cyc = 0; cyc < 600 && got < 24; cyc++) begin
      if (!bus.cmd_valid && sent < 24 && $urandom_range(0, 3) != 0) begin
        drive_vec({3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom), 4'h0});
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      #1;
      will_push = bus.cmd_valid & bus.cmd_ready;
      will_pop  = dut.fifo_pop;
      pre       = dut.fifo_count;
      if (will_push) begin q.push_back(alu_model(bus.cmd_sel, bus.cmd_a, bus.cmd_b, bus.cmd_c)); sent++; end
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL wrap_extra: got result %h with empty scoreboard", bus.res_data);
        end else begin
          exp = q.pop_front();
          if ({bus.res_ovr, bus.res_data} !== exp) begin
            errors++; $display("FAIL wrap_data_%0d: got ovr=%b d=%h want ovr=%b d=%h", got, bus.res_ovr, bus.res_data, exp[4], exp[3:0]);
          end
        end
        got++;
      end
      tick;
      if (will_push && will_pop) begin
        both++;
        checks++;
        if (dut.fifo_count !== pre) begin errors++; $display("FAIL wrap_pushpop: count got %0d want %0d", dut.fifo_count, pre); end
      end
      if (will_push) begin
        if (sent < 24 && $urandom_range(0, 3) != 0)
          drive_vec({3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom), 4'h0});
        else
          idle_cmd;
      end
    end
    idle_cmd;
    checks++;
    if ((got != 24) || (both == 0)) begin errors++; $display("FAIL wrap_totals: got results=%0d pushpop=%0d want 24 and >0", got, both); end
    bus.res_ready = 1'b1;
    repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    logic stale;
    bus.res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin drive_vec(or_vec(i)); tick; end
    idle_cmd;
    bus.res_ready = 1'b1;
    tick;                          // second command loaded, three queued
    bus.res_ready = 1'b0;
    checks++;
    if ({alu_a, bus.res_valid, busy, dut.fifo_count} !== {4'h2, 1'b0, 1'b1, 3'd3}) begin
      errors++; $display("FAIL rm_pre: got a=%h rv=%b busy=%b cnt=%0d want 2 0 1 3", alu_a, bus.res_valid, busy, dut.fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({alu_sel, alu_a, alu_b, alu_c, bus.res_valid, bus.res_data, bus.res_ovr, ovr_sticky, busy} !== 23'd0) begin
      errors++; $display("FAIL rm_reset: got sel=%h a=%h rv=%b d=%h st=%b busy=%b want all 0",
        alu_sel, alu_a, bus.res_valid, bus.res_data, ovr_sticky, busy);
    end
    tick;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    stale = 1'b0;
    repeat (5) begin tick; if (bus.res_valid) stale = 1'b1; end
    checks++;
    if ({stale, busy} !== 2'b00) begin errors++; $display("FAIL rm_stale: got stale=%b busy=%b want 0 0", stale, busy); end
    drive_vec({3'b010, 4'h2, 4'h3, 4'h0, 4'h0});
    tick; idle_cmd; tick; tick;
    checks++;
    if ({bus.res_valid, bus.res_data, bus.res_ovr} !== {1'b1, 4'h5, 1'b0}) begin
      errors++; $display("FAIL rm_after: got rv=%b d=%h ovr=%b want 1 5 0", bus.res_valid, bus.res_data, bus.res_ovr);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_single_sub;
    test_add_ovr_clr;
    test_backpressure;
    test_back_to_back;
    test_push_pop_full_minus_one;
    test_wrap_scoreboard;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
